// File: rtl/lsu_axi_master.sv
// ---------------------------------------------------------------------------
// lsu_axi_master
//   AXI-lite master for the load/store unit. Converts one core load or store
//   into an AR/R or AW/W/B transaction, places store data on the correct byte
//   lanes with a matching wstrb, and aligns plus sign/zero-extends load data.
//   Only one transaction is in flight; the core is back-pressured through
//   req_ready, which is high only in IDLE.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 core request (valid/ready, we, addr, wdata, size,
//                         unsigned)
//   resp_*                core response (valid/ready, rdata, err)
//   ar*/r*                AXI-lite read address / read data channels
//   aw*/w*/b*             AXI-lite write address / write data / response
//
// Parameters
//   CHECK_ALIGN           1: misaligned access answers resp_err with no AXI
//                         traffic; 0: no alignment check
// ---------------------------------------------------------------------------
module lsu_axi_master #(
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   // core request
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   // core response
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   // AXI-lite read
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   // AXI-lite write
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t      r_state;
   logic [1:0]  r_off;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_req_ready;
   logic        r_arvalid;
   logic        r_rready;
   logic        r_awvalid;
   logic        r_wvalid;
   logic        r_bready;
   logic        r_ar_done;
   logic        r_aw_done;
   logic        r_w_done;
   logic        r_b_done;
   logic [1:0]  r_bresp;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_err;

   // ---------------- request decode (used only in IDLE) ----------------
   logic [1:0]  w_off;
   logic        w_misaligned;
   logic [3:0]  w_strb_base;
   logic [3:0]  w_strb;
   logic [31:0] w_wdata;

   assign w_off = req_addr[1:0];

   // Size 3 is reserved and behaves like a word, hence req_size[1].
   assign w_misaligned = CHECK_ALIGN &&
                         (((req_size == 2'd1) && w_off[0]) ||
                          (req_size[1] && (w_off != 2'd0)));

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      w_strb_base = 4'b1111;
      case (req_size)
         2'd0:    w_strb_base = 4'b0001;
         2'd1:    w_strb_base = 4'b0011;
         default: w_strb_base = 4'b1111;
      endcase
   end

   assign w_strb  = w_strb_base << w_off;
   assign w_wdata = req_wdata << {w_off, 3'b000};

   // ---------------- read path ----------------
   logic        w_ar_hs;
   logic        w_r_hs;
   logic [31:0] w_sh;
   logic [31:0] w_load_data;

   assign w_ar_hs = r_arvalid & arready;
   // An R beat in the same cycle as the AR handshake is accepted.
   assign w_r_hs  = rvalid & r_rready & (r_ar_done | w_ar_hs);
   assign w_sh    = rdata >> {r_off, 3'b000};

   always_comb begin
      w_load_data = w_sh;
      case (r_size)
         2'd0:    w_load_data = {{24{~r_unsigned & w_sh[7]}},  w_sh[7:0]};
         2'd1:    w_load_data = {{16{~r_unsigned & w_sh[15]}}, w_sh[15:0]};
         default: w_load_data = w_sh;
      endcase
   end

   // ---------------- write path ----------------
   logic       w_b_hs;
   logic       w_aw_done;
   logic       w_w_done;
   logic       w_b_done;
   logic [1:0] w_bresp;

   assign w_b_hs    = bvalid & r_bready;
   assign w_aw_done = r_aw_done | (r_awvalid & awready);
   assign w_w_done  = r_w_done  | (r_wvalid  & wready);
   assign w_b_done  = r_b_done  | w_b_hs;
   assign w_bresp   = w_b_hs ? bresp : r_bresp;

   // ---------------- FSM with registered outputs ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_off        <= 2'd0;
         r_size       <= 2'd0;
         r_unsigned   <= 1'b0;
         r_addr       <= 32'd0;
         r_wdata      <= 32'd0;
         r_wstrb      <= 4'd0;
         r_req_ready  <= 1'b1;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_awvalid    <= 1'b0;
         r_wvalid     <= 1'b0;
         r_bready     <= 1'b0;
         r_ar_done    <= 1'b0;
         r_aw_done    <= 1'b0;
         r_w_done     <= 1'b0;
         r_b_done     <= 1'b0;
         r_bresp      <= 2'd0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_req_ready <= 1'b0;
                  r_off       <= w_off;
                  r_size      <= req_size;
                  r_unsigned  <= req_unsigned;
                  r_addr      <= {req_addr[31:2], 2'b00};
                  r_wdata     <= w_wdata;
                  r_wstrb     <= w_strb;
                  r_ar_done   <= 1'b0;
                  r_aw_done   <= 1'b0;
                  r_w_done    <= 1'b0;
                  r_b_done    <= 1'b0;
                  r_bresp     <= 2'd0;
                  if (w_misaligned) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= 32'd0;
                     r_resp_err   <= 1'b1;
                  end else if (req_we) begin
                     r_state   <= S_WR;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_bready  <= 1'b1;
                  end else begin
                     r_state   <= S_RD;
                     r_arvalid <= 1'b1;
                     r_rready  <= 1'b1;
                  end
               end
            end

            S_RD: begin
               if (w_ar_hs) begin
                  r_arvalid <= 1'b0;
                  r_ar_done <= 1'b1;
               end
               if (w_r_hs) begin
                  r_arvalid    <= 1'b0;
                  r_rready     <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= w_load_data;
                  r_resp_err   <= |rresp;
                  r_state      <= S_RESP;
               end
            end

            S_WR: begin
               if (r_awvalid && awready) r_awvalid <= 1'b0;
               if (r_wvalid && wready)   r_wvalid  <= 1'b0;
               r_aw_done <= w_aw_done;
               r_w_done  <= w_w_done;
               r_b_done  <= w_b_done;
               r_bresp   <= w_bresp;
               if (w_aw_done && w_w_done && w_b_done) begin
                  r_bready     <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= 32'd0;
                  r_resp_err   <= |w_bresp;
                  r_state      <= S_RESP;
               end
            end

            S_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign araddr     = r_addr;
   assign arvalid    = r_arvalid;
   assign rready     = r_rready;
   assign awaddr     = r_addr;
   assign awvalid    = r_awvalid;
   assign wdata      = r_wdata;
   assign wstrb      = r_wstrb;
   assign wvalid     = r_wvalid;
   assign bready     = r_bready;

endmodule
